// File: rtl/ones_count_pkg.sv
// Shared constants and state encoding for the chunked ones counter.
// The popcount datapath is fixed at 15 inputs, which gives a 4-bit result.
`timescale 1ns/1ns
package ones_count_pkg;

    localparam int CHUNK_W  = 15;
    localparam int CHUNK_CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ones_count_seq_if.sv
// Request/result bundle between a controller and the chunked ones counter.
// The controller drives start and data_in and reads back status and count.
`timescale 1ns/1ns
interface ones_count_seq_if #(
    parameter int NUM_CHUNKS = 4
);
    import ones_count_pkg::*;

    localparam int W  = CHUNK_W * NUM_CHUNKS;
    localparam int CW = $clog2(W + 1);

    logic          start;
    logic [W-1:0]  data_in;
    logic          ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    modport master (
        output start,
        output data_in,
        input  ready,
        input  busy,
        input  done,
        input  count
    );

    modport slave (
        input  start,
        input  data_in,
        output ready,
        output busy,
        output done,
        output count
    );

endinterface

// File: rtl/popcnt15.sv
// Combinational 15-input ones counter; the single shared datapath of the block.
// Built as a ripple of small adders so each stage stays 4 bits wide.
`timescale 1ns/1ns
module popcnt15
    import ones_count_pkg::*;
(
    input  logic [CHUNK_W-1:0]  bits,
    output logic [CHUNK_CW-1:0] ones
);

    logic [CHUNK_CW-1:0] partial [CHUNK_W+1];

    assign partial[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK_W; gi++) begin : g_sum
            assign partial[gi+1] = partial[gi] + CHUNK_CW'(bits[gi]);
        end
    endgenerate

    assign ones = partial[CHUNK_W];

endmodule

// File: rtl/ones_count_seq.sv
// Multi-cycle ones counter: captures a NUM_CHUNKS*15-bit word and runs one 15-bit
// chunk per cycle (LSB chunk first) through a shared popcount, accumulating the total.
`timescale 1ns/1ns
module ones_count_seq
    import ones_count_pkg::*;
#(
    parameter int NUM_CHUNKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    ones_count_seq_if.slave  bus
);

    localparam int W  = CHUNK_W * NUM_CHUNKS;
    localparam int CW = $clog2(W + 1);
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    state_t              state_reg;
    state_t              state_next;
    logic [W-1:0]        shift_reg;
    logic [CW-1:0]       acc_reg;
    logic [IW-1:0]       idx_reg;
    logic [CHUNK_CW-1:0] chunk_ones;
    logic                last_chunk;
    logic                load;

    popcnt15 u_popcnt15 (
        .bits (shift_reg[CHUNK_W-1:0]),
        .ones (chunk_ones)
    );

    assign last_chunk = (idx_reg == IW'(NUM_CHUNKS - 1));
    // A start is only honoured outside RUN, so a request mid-job has no effect.
    assign load       = bus.start && (state_reg != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_reg)
            RUN: begin
                bus.ready = 1'b0;
                bus.busy  = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            acc_reg   <= '0;
            idx_reg   <= '0;
        end else if (load) begin
            shift_reg <= bus.data_in;
            acc_reg   <= '0;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            acc_reg   <= acc_reg + CW'(chunk_ones);
            shift_reg <= shift_reg >> CHUNK_W;
            idx_reg   <= idx_reg + IW'(1);
        end
    end

    // The accumulator doubles as the result register and holds until the next load.
    assign bus.count = acc_reg;

endmodule

// File: tb/tb_ones_count_seq.sv
// Directed bench for ones_count_seq: a 4-chunk instance for the main sequence and a
// 1-chunk instance for the single-cycle RUN case.
`timescale 1ns/1ns
module tb_ones_count_seq;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ones_count_seq_if #(.NUM_CHUNKS(4)) bus4 ();
    ones_count_seq_if #(.NUM_CHUNKS(1)) bus1 ();

    ones_count_seq #(.NUM_CHUNKS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    ones_count_seq #(.NUM_CHUNKS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a job on the next edge; afterwards we sit in the first RUN cycle.
    task automatic start_job(input logic [59:0] d, input string tag);
        bus4.start   = 1'b1;
        bus4.data_in = d;
        tick();
        bus4.start   = 1'b0;
        check({tag, "_busy"},  64'(bus4.busy),  64'd1);
        check({tag, "_clear"}, 64'(bus4.count), 64'd0);
    endtask

    task automatic wait_done(input int lat, input logic [5:0] exp, input string tag);
        int n = 0;
        while (!bus4.done && n < 20) begin
            tick();
            n++;
        end
        $display("job %s: count=%0d latency=%0d", tag, bus4.count, n);
        check({tag, "_latency"}, 64'(n),          64'(lat));
        check({tag, "_done"},    64'(bus4.done),  64'd1);
        check({tag, "_count"},   64'(bus4.count), 64'(exp));
        check({tag, "_ready"},   64'(bus4.ready), 64'd1);
    endtask

    task automatic after_done(input logic [5:0] exp, input string tag);
        tick();
        check({tag, "_pulse"}, 64'(bus4.done),  64'd0);
        check({tag, "_idle"},  64'(bus4.busy),  64'd0);
        check({tag, "_hold"},  64'(bus4.count), 64'(exp));
    endtask

    task automatic run_job(input logic [59:0] d, input logic [5:0] exp, input string tag);
        start_job(d, tag);
        wait_done(4, exp, tag);
        after_done(exp, tag);
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        bus4.start   = 1'b0;
        bus4.data_in = '0;
        bus1.start   = 1'b0;
        bus1.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus4.ready), 64'd1);
        check("rst_busy",  64'(bus4.busy),  64'd0);
        check("rst_done",  64'(bus4.done),  64'd0);
        check("rst_count", 64'(bus4.count), 64'd0);
        rst = 1'b0;
        tick();

        // All ones, zeros, then a single one to show the stale total is cleared
        run_job(60'hFFF_FFFF_FFFF_FFFF, 6'd60, "all_ones");
        run_job(60'h0, 6'd0, "zeros");
        run_job(60'h1, 6'd1, "one_bit");
        run_job(60'hAAA_AAAA_AAAA_AAAA, 6'd30, "alternating");
        run_job({15'h7FFF, 45'h0}, 6'd15, "msb_chunk");

        // Chunks with 1,2,3,4 ones: running totals reveal LSB-first order
        start_job({15'h000F, 15'h0007, 15'h0003, 15'h0001}, "stair");
        tick();
        check("stair_c0", 64'(bus4.count), 64'd1);
        tick();
        check("stair_c1", 64'(bus4.count), 64'd3);
        tick();
        check("stair_c2", 64'(bus4.count), 64'd6);
        wait_done(1, 6'd10, "stair");
        after_done(6'd10, "stair");

        // Start pulsed during RUN with other data must be ignored
        start_job(60'h1, "ignore");
        bus4.start   = 1'b1;
        bus4.data_in = 60'hFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        bus4.start = 1'b0;
        wait_done(2, 6'd1, "ignore");
        after_done(6'd1, "ignore");

        // Async reset in RUN cycle 2 aborts the job with no done pulse
        start_job(60'hFFF_FFFF_FFFF_FFFF, "abort");
        tick();
        rst = 1'b1;
        #1;
        check("abort_count", 64'(bus4.count), 64'd0);
        check("abort_ready", 64'(bus4.ready), 64'd1);
        check("abort_busy",  64'(bus4.busy),  64'd0);
        check("abort_done",  64'(bus4.done),  64'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (bus4.done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_job(60'hAAA_AAAA_AAAA_AAAA, 6'd30, "post_abort");

        // Start held high: the next job begins straight out of DONE
        bus4.start   = 1'b1;
        bus4.data_in = 60'hFFF_FFFF_FFFF_FFFF;
        tick();
        wait_done(4, 6'd60, "b2b_a");
        bus4.data_in = 60'h3;
        tick();
        bus4.start = 1'b0;
        check("b2b_busy",  64'(bus4.busy),  64'd1);
        check("b2b_clear", 64'(bus4.count), 64'd0);
        wait_done(4, 6'd2, "b2b_b");
        after_done(6'd2, "b2b_b");

        // Single-chunk instance: RUN is one cycle, two jobs back to back
        bus1.start   = 1'b1;
        bus1.data_in = 15'h7FFF;
        tick();
        check("c1_busy", 64'(bus1.busy), 64'd1);
        bus1.data_in = 15'h0101;
        tick();
        $display("job c1_a: count=%0d done=%0d", bus1.count, bus1.done);
        check("c1_a_done",  64'(bus1.done),  64'd1);
        check("c1_a_count", 64'(bus1.count), 64'd15);
        tick();
        bus1.start = 1'b0;
        check("c1_b_busy",  64'(bus1.busy),  64'd1);
        check("c1_b_clear", 64'(bus1.count), 64'd0);
        tick();
        $display("job c1_b: count=%0d done=%0d", bus1.count, bus1.done);
        check("c1_b_done",  64'(bus1.done),  64'd1);
        check("c1_b_count", 64'(bus1.count), 64'd2);
        tick();
        check("c1_idle_done",  64'(bus1.done),  64'd0);
        check("c1_idle_ready", 64'(bus1.ready), 64'd1);
        check("c1_idle_count", 64'(bus1.count), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
